// File: rtl/comp_pkg.sv
// comp_pkg: shared state encoding and golden comparator function for the comparator self-test
package comp_pkg;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_DRIVE  = 3'd1;
    localparam logic [2:0] ENC_SETTLE = 3'd2;
    localparam logic [2:0] ENC_CHECK  = 3'd3;
    localparam logic [2:0] ENC_DONE   = 3'd4;

    localparam int MAX_WIDTH = 32;

    // State names carry an ST_ prefix so they never collide with the SETTLE parameter
    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_DRIVE  = ENC_DRIVE,
        ST_SETTLE = ENC_SETTLE,
        ST_CHECK  = ENC_CHECK,
        ST_DONE   = ENC_DONE
    } state_t;

    // Unsigned compare returning {l,e,g}; callers zero-extend narrower operands
    function automatic logic [2:0] golden_cmp(input logic [MAX_WIDTH-1:0] a, input logic [MAX_WIDTH-1:0] b);
        return {a < b, a == b, a > b};
    endfunction

endpackage

// File: rtl/comp_golden.sv
// comp_golden: combinational reference comparator producing {l,e,g}
module comp_golden
    import comp_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       leg
);

    // Zero-extend to the function width and evaluate the reference compare
    always_comb begin
        leg = golden_cmp(MAX_WIDTH'(a), MAX_WIDTH'(b));
    end

endmodule

// File: rtl/comp_selftest_ctrl.sv
// comp_selftest_ctrl: sweeps every operand pair into a comparator and checks l/e/g against a golden compare
module comp_selftest_ctrl
    import comp_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1,
    parameter int ERRW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic             l_in,
    input  logic             e_in,
    input  logic             g_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int VW = 2 * WIDTH;

    state_t          state;
    logic [VW-1:0]   vec;
    logic [3:0]      cnt;
    logic [2:0]      gold;
    logic            mismatch;

    // Reference compare of the operands currently presented to the comparator
    comp_golden #(.WIDTH(WIDTH)) u_golden (
        .a   (a_out),
        .b   (b_out),
        .leg (gold)
    );

    // Any bit difference is an error, including non-one-hot responses
    always_comb begin
        mismatch = {l_in, e_in, g_in} != gold;
    end

    // Sweep FSM with counters and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            vec       <= '0;
            cnt       <= '0;
            a_out     <= '0;
            b_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_DRIVE;
                        vec       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_a    <= '0;
                        fail_b    <= '0;
                    end
                end
                ST_DRIVE: begin
                    {a_out, b_out} <= vec;
                    cnt            <= '0;
                    state          <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == 4'(SETTLE - 1))
                        state <= ST_CHECK;
                    else
                        cnt <= cnt + 4'd1;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1)
                            err_count <= err_count + 1'b1;
                        // err_count saturates and never returns to zero, so zero marks the first error
                        if (err_count == '0) begin
                            fail_a <= a_out;
                            fail_b <= b_out;
                        end
                    end
                    if (vec == '1) begin
                        state <= ST_DONE;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= err_count == '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
